// File: rtl/ysyx_22040750_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// State encoding, instruction width and the default reset PC.
package ysyx_22040750_ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_PC   = 2'd3
    } ifu_state_e;

    localparam int unsigned INST_W       = 32;
    localparam int unsigned PERF_W       = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22040750_ifu_perf.sv
// Fetch performance counters: completed fetches and request/response stall cycles.
// Only instantiated when YSYX_22040750_IFU_PERF_EN is defined.
module ysyx_22040750_ifu_perf
    import ysyx_22040750_ifu_pkg::*;
(
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_fetch_inc,
    input  logic              I_stall_inc,
    output logic [PERF_W-1:0] O_fetch_cnt,
    output logic [PERF_W-1:0] O_stall_cnt
);

    logic [PERF_W-1:0] fetch_cnt_q;
    logic [PERF_W-1:0] stall_cnt_q;

    // Both counters wrap naturally at 2^PERF_W.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (I_fetch_inc) begin
                fetch_cnt_q <= fetch_cnt_q + PERF_W'(1);
            end
            if (I_stall_inc) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
        end
    end

    assign O_fetch_cnt = fetch_cnt_q;
    assign O_stall_cnt = stall_cnt_q;

endmodule

// File: rtl/ysyx_22040750_ifu.sv
// Instruction fetch stage: owns the fetch PC, one outstanding imem read, flush-aware.
// Optional perf counters enabled by defining YSYX_22040750_IFU_PERF_EN.
module ysyx_22040750_ifu
    import ysyx_22040750_ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic [XLEN-1:0]   I_dnpc,
    input  logic              I_dnpc_valid,
    output logic              O_pc_ready,
    input  logic              I_flush,
    output logic              O_mem_req_valid,
    input  logic              I_mem_req_ready,
    output logic [XLEN-1:0]   O_mem_addr,
    input  logic              I_mem_rsp_valid,
    input  logic [INST_W-1:0] I_mem_rsp_data,
    output logic              O_mem_rsp_ready,
    output logic              O_IF_ID_valid,
    input  logic              I_IF_ID_ready,
    output logic [XLEN-1:0]   O_IF_ID_pc,
    output logic [XLEN-1:0]   O_IF_ID_snpc,
    output logic [INST_W-1:0] O_IF_ID_inst
`ifdef YSYX_22040750_IFU_PERF_EN
    ,
    output logic [PERF_W-1:0] O_fetch_cnt,
    output logic [PERF_W-1:0] O_stall_cnt
`endif
);

    ifu_state_e        state_q;
    logic [XLEN-1:0]   pc_q;
    logic              drop_q;
    logic [INST_W-1:0] inst_q;

    logic req_hs;
    logic rsp_hs;
    logic unused_dnpc_lsb;

    assign req_hs = (state_q == S_REQ)  && I_mem_req_ready;
    assign rsp_hs = (state_q == S_WAIT) && I_mem_rsp_valid;

    // Targets are word aligned; the low two bits of dnpc are ignored.
    assign unused_dnpc_lsb = ^I_dnpc[1:0];

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            inst_q  <= '0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_hs) begin
                        // Request already left; its response must be swallowed later.
                        state_q <= S_WAIT;
                        if (I_flush) begin
                            drop_q <= 1'b1;
                        end
                    end else if (I_flush) begin
                        state_q <= S_PC;
                    end
                end
                S_WAIT: begin
                    if (rsp_hs) begin
                        if (drop_q || I_flush) begin
                            drop_q  <= 1'b0;
                            state_q <= S_PC;
                        end else begin
                            inst_q  <= I_mem_rsp_data;
                            state_q <= S_OUT;
                        end
                    end else if (I_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (I_flush || I_IF_ID_ready) begin
                        state_q <= S_PC;
                    end
                end
                S_PC: begin
                    if (I_dnpc_valid) begin
                        pc_q    <= {I_dnpc[XLEN-1:2], 2'b00};
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    // All handshake and data outputs are decoded purely from registered state.
    always_comb begin
        O_mem_req_valid = 1'b0;
        O_mem_addr      = '0;
        O_mem_rsp_ready = 1'b0;
        O_IF_ID_valid   = 1'b0;
        O_IF_ID_pc      = '0;
        O_IF_ID_snpc    = '0;
        O_IF_ID_inst    = '0;
        O_pc_ready      = 1'b0;
        unique case (state_q)
            S_REQ: begin
                O_mem_req_valid = 1'b1;
                O_mem_addr      = pc_q;
            end
            S_WAIT: begin
                O_mem_rsp_ready = 1'b1;
            end
            S_OUT: begin
                O_IF_ID_valid = 1'b1;
                O_IF_ID_pc    = pc_q;
                O_IF_ID_snpc  = pc_q + XLEN'(4);
                O_IF_ID_inst  = inst_q;
            end
            S_PC: begin
                O_pc_ready = 1'b1;
            end
            default: begin
                O_pc_ready = 1'b0;
            end
        endcase
    end

`ifdef YSYX_22040750_IFU_PERF_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = rsp_hs && !drop_q && !I_flush;
    assign stall_inc = ((state_q == S_REQ)  && !I_mem_req_ready) ||
                       ((state_q == S_WAIT) && !I_mem_rsp_valid);

    ysyx_22040750_ifu_perf u_perf (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_fetch_inc (fetch_inc),
        .I_stall_inc (stall_inc),
        .O_fetch_cnt (O_fetch_cnt),
        .O_stall_cnt (O_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// Directed self-checking bench for ysyx_22040750_ifu: fetch, back-pressure, flush cases, wrap.
// Perf counter checks run only when YSYX_22040750_IFU_PERF_EN is defined.
module tb_ysyx_22040750_ifu;

    logic        I_clk;
    logic        I_rst;
    logic [31:0] I_dnpc;
    logic        I_dnpc_valid;
    logic        O_pc_ready;
    logic        I_flush;
    logic        O_mem_req_valid;
    logic        I_mem_req_ready;
    logic [31:0] O_mem_addr;
    logic        I_mem_rsp_valid;
    logic [31:0] I_mem_rsp_data;
    logic        O_mem_rsp_ready;
    logic        O_IF_ID_valid;
    logic        I_IF_ID_ready;
    logic [31:0] O_IF_ID_pc;
    logic [31:0] O_IF_ID_snpc;
    logic [31:0] O_IF_ID_inst;
`ifdef YSYX_22040750_IFU_PERF_EN
    logic [31:0] O_fetch_cnt;
    logic [31:0] O_stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_22040750_ifu dut (
        .I_clk           (I_clk),
        .I_rst           (I_rst),
        .I_dnpc          (I_dnpc),
        .I_dnpc_valid    (I_dnpc_valid),
        .O_pc_ready      (O_pc_ready),
        .I_flush         (I_flush),
        .O_mem_req_valid (O_mem_req_valid),
        .I_mem_req_ready (I_mem_req_ready),
        .O_mem_addr      (O_mem_addr),
        .I_mem_rsp_valid (I_mem_rsp_valid),
        .I_mem_rsp_data  (I_mem_rsp_data),
        .O_mem_rsp_ready (O_mem_rsp_ready),
        .O_IF_ID_valid   (O_IF_ID_valid),
        .I_IF_ID_ready   (I_IF_ID_ready),
        .O_IF_ID_pc      (O_IF_ID_pc),
        .O_IF_ID_snpc    (O_IF_ID_snpc),
        .O_IF_ID_inst    (O_IF_ID_inst)
`ifdef YSYX_22040750_IFU_PERF_EN
        ,
        .O_fetch_cnt     (O_fetch_cnt),
        .O_stall_cnt     (O_stall_cnt)
`endif
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    initial begin
        I_rst           = 1'b1;
        I_dnpc          = '0;
        I_dnpc_valid    = 1'b0;
        I_flush         = 1'b0;
        I_mem_req_ready = 1'b0;
        I_mem_rsp_valid = 1'b0;
        I_mem_rsp_data  = '0;
        I_IF_ID_ready   = 1'b0;
        repeat (2) step();
        I_rst = 1'b0;

        // Reset state: S_REQ at RESET_PC.
        check_eq("rst_req_valid", 32'(O_mem_req_valid), 32'd1);
        check_eq("rst_addr",      O_mem_addr,           32'h8000_0000);
        check_eq("rst_pc_ready",  32'(O_pc_ready),      32'd0);
        check_eq("rst_ifid_vld",  32'(O_IF_ID_valid),   32'd0);
        check_eq("rst_rsp_ready", 32'(O_mem_rsp_ready), 32'd0);

        // Basic fetch, response two cycles after the request handshake.
        I_mem_req_ready = 1'b1;
        step();
        I_mem_req_ready = 1'b0;
        check_eq("f1_rsp_ready", 32'(O_mem_rsp_ready), 32'd1);
        check_eq("f1_req_low",   32'(O_mem_req_valid), 32'd0);
        step();
        I_mem_rsp_valid = 1'b1;
        I_mem_rsp_data  = 32'h0000_0413;
        step();
        I_mem_rsp_valid = 1'b0;
        check_eq("f1_valid", 32'(O_IF_ID_valid), 32'd1);
        check_eq("f1_pc",    O_IF_ID_pc,         32'h8000_0000);
        check_eq("f1_snpc",  O_IF_ID_snpc,       32'h8000_0004);
        check_eq("f1_inst",  O_IF_ID_inst,       32'h0000_0413);

        // IF/ID back-pressure for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_valid",    32'(O_IF_ID_valid), 32'd1);
            check_eq("bp_inst",     O_IF_ID_inst,       32'h0000_0413);
            check_eq("bp_pc",       O_IF_ID_pc,         32'h8000_0000);
            check_eq("bp_pc_ready", 32'(O_pc_ready),    32'd0);
        end
        I_IF_ID_ready = 1'b1;
        step();
        I_IF_ID_ready = 1'b0;
        check_eq("bp_to_pc",   32'(O_pc_ready),    32'd1);
        check_eq("bp_vld_off", 32'(O_IF_ID_valid), 32'd0);
        I_dnpc       = 32'h8000_0010;
        I_dnpc_valid = 1'b1;
        step();
        I_dnpc_valid = 1'b0;
        check_eq("f2_req_valid", 32'(O_mem_req_valid), 32'd1);
        check_eq("f2_addr",      O_mem_addr,           32'h8000_0010);

        // Response ignored outside S_WAIT.
        I_mem_rsp_valid = 1'b1;
        #1;
        check_eq("req_no_rsp_rdy", 32'(O_mem_rsp_ready), 32'd0);
        I_mem_rsp_valid = 1'b0;

        // Flush while waiting; late response must be dropped.
        I_mem_req_ready = 1'b1;
        step();
        I_mem_req_ready = 1'b0;
        I_flush = 1'b1;
        step();
        I_flush = 1'b0;
        check_eq("fw_rsp_ready", 32'(O_mem_rsp_ready), 32'd1);
        step();
        check_eq("fw_no_valid", 32'(O_IF_ID_valid), 32'd0);
        step();
        I_mem_rsp_valid = 1'b1;
        I_mem_rsp_data  = 32'hDEAD_BEEF;
        step();
        I_mem_rsp_valid = 1'b0;
        check_eq("fw_drop_valid", 32'(O_IF_ID_valid), 32'd0);
        check_eq("fw_pc_ready",   32'(O_pc_ready),    32'd1);
        I_dnpc       = 32'h8000_0020;
        I_dnpc_valid = 1'b1;
        step();
        I_dnpc_valid = 1'b0;
        check_eq("fw_next_addr", O_mem_addr, 32'h8000_0020);

        // Flush coinciding with the request handshake.
        I_mem_req_ready = 1'b1;
        I_flush         = 1'b1;
        step();
        I_mem_req_ready = 1'b0;
        I_flush         = 1'b0;
        check_eq("fr_rsp_ready", 32'(O_mem_rsp_ready), 32'd1);
        I_mem_rsp_valid = 1'b1;
        I_mem_rsp_data  = 32'h1234_5678;
        step();
        I_mem_rsp_valid = 1'b0;
        check_eq("fr_drop_valid", 32'(O_IF_ID_valid), 32'd0);
        check_eq("fr_pc_ready",   32'(O_pc_ready),    32'd1);

        // Flush in S_REQ without handshake aborts to S_PC.
        I_dnpc       = 32'h8000_0030;
        I_dnpc_valid = 1'b1;
        step();
        I_dnpc_valid = 1'b0;
        check_eq("fq_addr", O_mem_addr, 32'h8000_0030);
        I_flush = 1'b1;
        step();
        I_flush = 1'b0;
        check_eq("fq_pc_ready",  32'(O_pc_ready),      32'd1);
        check_eq("fq_req_valid", 32'(O_mem_req_valid), 32'd0);

        // Flush in S_PC is ignored and the dnpc handshake still happens.
        I_dnpc       = 32'hFFFF_FFFC;
        I_dnpc_valid = 1'b1;
        I_flush      = 1'b1;
        step();
        I_dnpc_valid = 1'b0;
        I_flush      = 1'b0;
        check_eq("fp_addr", O_mem_addr, 32'hFFFF_FFFC);
        I_mem_req_ready = 1'b1;
        step();
        I_mem_req_ready = 1'b0;
        I_mem_rsp_valid = 1'b1;
        I_mem_rsp_data  = 32'h0010_0073;
        step();
        I_mem_rsp_valid = 1'b0;
        check_eq("wrap_pc",   O_IF_ID_pc,   32'hFFFF_FFFC);
        check_eq("wrap_snpc", O_IF_ID_snpc, 32'h0000_0000);
        check_eq("wrap_inst", O_IF_ID_inst, 32'h0010_0073);

        // Flush in S_OUT wins over ready.
        I_flush       = 1'b1;
        I_IF_ID_ready = 1'b1;
        step();
        I_flush       = 1'b0;
        I_IF_ID_ready = 1'b0;
        check_eq("fo_valid",    32'(O_IF_ID_valid), 32'd0);
        check_eq("fo_pc_ready", 32'(O_pc_ready),    32'd1);

        // Misaligned dnpc is word aligned.
        I_dnpc       = 32'h8000_0007;
        I_dnpc_valid = 1'b1;
        step();
        I_dnpc_valid = 1'b0;
        check_eq("align_addr", O_mem_addr, 32'h8000_0004);

`ifdef YSYX_22040750_IFU_PERF_EN
        // Fresh reset: 3 fetches, one flushed, 4 stall cycles.
        I_rst = 1'b1;
        step();
        I_rst = 1'b0;
        check_eq("perf_rst_fetch", O_fetch_cnt, 32'd0);
        check_eq("perf_rst_stall", O_stall_cnt, 32'd0);
        step();                                 // stall 1 in S_REQ
        I_mem_req_ready = 1'b1;
        step();
        I_mem_req_ready = 1'b0;
        step();                                 // stall 2 in S_WAIT
        I_mem_rsp_valid = 1'b1;
        step();
        I_mem_rsp_valid = 1'b0;
        I_IF_ID_ready   = 1'b1;
        step();
        I_IF_ID_ready   = 1'b0;
        I_dnpc          = 32'h8000_0040;
        I_dnpc_valid    = 1'b1;
        step();
        I_dnpc_valid    = 1'b0;
        I_mem_req_ready = 1'b1;
        step();
        I_mem_req_ready = 1'b0;
        I_flush         = 1'b1;
        step();                                 // stall 3 in S_WAIT, flushed
        I_flush         = 1'b0;
        I_mem_rsp_valid = 1'b1;
        step();
        I_mem_rsp_valid = 1'b0;
        I_dnpc_valid    = 1'b1;
        step();
        I_dnpc_valid    = 1'b0;
        step();                                 // stall 4 in S_REQ
        I_mem_req_ready = 1'b1;
        step();
        I_mem_req_ready = 1'b0;
        I_mem_rsp_valid = 1'b1;
        step();
        I_mem_rsp_valid = 1'b0;
        check_eq("perf_fetch", O_fetch_cnt, 32'd2);
        check_eq("perf_stall", O_stall_cnt, 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
